// File: rtl/instruction_memory_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_memory_loader
//  Purpose  : Boot-time loader for the core's instruction memory. Packs a
//             valid/ready byte stream big-endian into DWL-bit words and
//             writes them at consecutive word addresses from 0. The CPU is
//             held off until the requested number of words has been written.
//  Ports    : i_clk, i_rst_n (async, active-low)
//             i_start, i_len           session request and word count
//             i_byte_in, i_byte_valid  byte stream in; o_byte_ready back
//             o_imwe, o_imwa, o_imwd   instruction-memory write port
//             o_busy, o_done, o_cpu_hold  session status
//  Revision : 1.0  initial release
// ============================================================================
module instruction_memory_loader #(
  parameter int AWL   = 6,
  parameter int DWL   = 32,
  parameter int DEPTH = 2**AWL
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [AWL:0]   i_len,
  input  logic [7:0]     i_byte_in,
  input  logic           i_byte_valid,
  output logic           o_byte_ready,
  output logic           o_imwe,
  output logic [AWL-1:0] o_imwa,
  output logic [DWL-1:0] o_imwd,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_cpu_hold
);

  localparam int c_BPW = DWL / 8;
  localparam int c_BCW = $clog2(c_BPW + 1);
  localparam logic [c_BCW-1:0] c_LAST_BYTE = c_BCW'(c_BPW - 1);
  localparam logic [AWL:0]     c_DEPTH_LEN = (AWL + 1)'(DEPTH);

  localparam logic [1:0] c_S_IDLE    = 2'd0;
  localparam logic [1:0] c_S_COLLECT = 2'd1;
  localparam logic [1:0] c_S_WRITE   = 2'd2;
  localparam logic [1:0] c_S_DONE    = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [AWL:0]     r_len;
  logic [AWL:0]     r_word_cnt;
  logic [AWL:0]     w_word_inc;
  logic [AWL:0]     w_len_clamped;
  logic [AWL-1:0]   r_addr;
  logic [AWL-1:0]   r_imwa;
  logic [c_BCW-1:0] r_byte_cnt;
  logic [DWL-1:0]   r_shift;
  logic [DWL-1:0]   r_imwd;
  logic [DWL-1:0]   w_shift_next;
  logic             w_accept_start;
  logic             w_handshake;
  logic             w_last_byte;

  // START is only honoured between sessions; mid-session pulses are dropped.
  assign w_accept_start = i_start & ((r_state == c_S_IDLE) | (r_state == c_S_DONE));
  // Ready is state-decoded, so the handshake reduces to valid while collecting.
  assign w_handshake    = (r_state == c_S_COLLECT) & i_byte_valid;
  assign w_last_byte    = w_handshake & (r_byte_cnt == c_LAST_BYTE);
  // First byte of a word ends up in the most significant byte (big-endian).
  assign w_shift_next   = (r_shift << 8) | DWL'(i_byte_in);
  assign w_word_inc     = r_word_cnt + (AWL + 1)'(1);
  // Out-of-range lengths are clamped so the session still ends at DEPTH words.
  assign w_len_clamped  = (i_len > c_DEPTH_LEN) ? c_DEPTH_LEN : i_len;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE, c_S_DONE: begin
        if (w_accept_start) begin
          w_next_state = (i_len == '0) ? c_S_DONE : c_S_COLLECT;
        end
      end
      c_S_COLLECT: begin
        if (w_last_byte) begin
          w_next_state = c_S_WRITE;
        end
      end
      c_S_WRITE: begin
        w_next_state = (w_word_inc == r_len) ? c_S_DONE : c_S_COLLECT;
      end
      default: begin
        w_next_state = c_S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs, decoded from state or taken from registers only
  // --------------------------------------------------------------------------
  always_comb begin
    o_byte_ready = (r_state == c_S_COLLECT);
    o_imwe       = (r_state == c_S_WRITE);
    o_busy       = (r_state == c_S_COLLECT) | (r_state == c_S_WRITE);
    o_done       = (r_state == c_S_DONE);
    o_cpu_hold   = (r_state != c_S_DONE);
    o_imwa       = r_imwa;
    o_imwd       = r_imwd;
  end

  // --------------------------------------------------------------------------
  // Datapath: counters, byte packer and write-port registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len      <= '0;
      r_word_cnt <= '0;
      r_addr     <= '0;
      r_byte_cnt <= '0;
      r_shift    <= '0;
      r_imwa     <= '0;
      r_imwd     <= '0;
    end else begin
      if (w_accept_start) begin
        r_len      <= w_len_clamped;
        r_word_cnt <= '0;
        r_addr     <= '0;
        r_byte_cnt <= '0;
      end

      if (w_handshake) begin
        r_shift <= w_shift_next;
        if (w_last_byte) begin
          r_byte_cnt <= '0;
          // Write port is loaded as the word completes, so it is valid for
          // the whole WRITE cycle and then holds until the next word.
          r_imwd     <= w_shift_next;
          r_imwa     <= r_addr;
        end else begin
          r_byte_cnt <= r_byte_cnt + c_BCW'(1);
        end
      end

      if (r_state == c_S_WRITE) begin
        r_word_cnt <= w_word_inc;
        // Wraps to 0 only after the DEPTH-th word, when the session ends.
        r_addr     <= r_addr + AWL'(1);
        r_byte_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_memory_loader
//  Purpose  : Directed self-checking bench for instruction_memory_loader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instruction_memory_loader;

  localparam int AWL = 6;
  localparam int DWL = 32;
  localparam int OW  = 5 + AWL + DWL;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [AWL:0]   len = '0;
  logic [7:0]     byte_in = '0;
  logic           byte_valid = 1'b0;
  logic           byte_ready;
  logic           imwe;
  logic [AWL-1:0] imwa;
  logic [DWL-1:0] imwd;
  logic           busy;
  logic           done;
  logic           cpu_hold;

  instruction_memory_loader #(.AWL(AWL), .DWL(DWL), .DEPTH(2**AWL)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_len        (len),
    .i_byte_in    (byte_in),
    .i_byte_valid (byte_valid),
    .o_byte_ready (byte_ready),
    .o_imwe       (imwe),
    .o_imwa       (imwa),
    .o_imwd       (imwd),
    .o_busy       (busy),
    .o_done       (done),
    .o_cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AWL-1:0] wr_addr_q[$];
  logic [DWL-1:0] wr_data_q[$];
  int             wr_cyc_q[$];
  logic [7:0]     stim_q[$];

  // Write-port monitor: records every write the memory would see.
  always @(negedge clk) begin
    if (imwe === 1'b1) begin
      wr_addr_q.push_back(imwa);
      wr_data_q.push_back(imwd);
      wr_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- helpers
  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pulses START before edge k; returns at the negedge just after edge k.
  task automatic do_start(input logic [AWL:0] l, output int k);
    start = 1'b1;
    len = l;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Byte source: a byte moves on when valid and ready were both high
  // across an edge. pulse_at >= 0 fires a stray START with LEN=5.
  task automatic stream(input bit gaps, input int pulse_at, input int budget,
                        output bit timed_out);
    int idx = 0;
    int cycles = 0;
    bit hs;
    timed_out = 1'b0;
    while (idx < stim_q.size()) begin
      byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      byte_in = stim_q[idx];
      start = (cycles == pulse_at);
      if (start) len = 7'd5;
      hs = byte_valid & byte_ready;
      @(negedge clk);
      if (hs) idx++;
      cycles++;
      if (cycles > budget) begin
        timed_out = 1'b1;
        break;
      end
    end
    byte_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    logic [OW-1:0] obs;
    logic [OW-1:0] exp_v;
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {AWL{1'b0}}, {DWL{1'b0}}};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    obs = {byte_ready, imwe, busy, done, cpu_hold, imwa, imwd};
    n_checks++;
    if (obs !== exp_v) $display("FAIL reset_values: got %h expected %h", obs, exp_v);
    else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      obs = {byte_ready, imwe, busy, done, cpu_hold, imwa, imwd};
      n_checks++;
      if (obs !== exp_v) $display("FAIL idle_no_start[%0d]: got %h expected %h", i, obs, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_single_word();
    int k;
    bit to;
    clear_writes();
    stim_q = '{8'h8C, 8'h01, 8'h00, 8'h04};
    do_start(7'd1, k);
    n_checks++;
    if ({byte_ready, busy, cpu_hold, done} !== 4'b1110)
      $display("FAIL single_collect_state: got %b expected 1110", {byte_ready, busy, cpu_hold, done});
    else n_pass++;
    stream(1'b0, -1, 20, to);
    n_checks++;
    if (to !== 1'b0 || imwe !== 1'b1 || byte_ready !== 1'b0)
      $display("FAIL single_write_cycle: timeout=%b imwe=%b ready=%b expected 0 1 0", to, imwe, byte_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({done, cpu_hold, busy, imwe} !== 4'b1000)
      $display("FAIL single_done: got done/hold/busy/imwe=%b expected 1000", {done, cpu_hold, busy, imwe});
    else n_pass++;
    n_checks++;
    if (wr_addr_q.size() != 1)
      $display("FAIL single_write_count: got %0d expected 1", wr_addr_q.size());
    else if (wr_addr_q[0] !== 6'd0 || wr_data_q[0] !== 32'h8C010004 || wr_cyc_q[0] != k + 4)
      $display("FAIL single_write: got addr %0d data %h cyc %0d expected 0 8c010004 %0d",
               wr_addr_q[0], wr_data_q[0], wr_cyc_q[0], k + 4);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int k;
    bit to;
    bit ok;
    clear_writes();
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_start(7'd2, k);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_done_drops: got done=%b busy=%b expected 0 1", done, busy);
    else n_pass++;
    // Valid stays high through the WRITE cycle; a stray START lands there too.
    stream(1'b0, 4, 30, to);
    wait_done(10, ok);
    n_checks++;
    if (to || !ok || cyc != k + 10)
      $display("FAIL b2b_done_time: timeout=%b done=%b cyc %0d expected done at %0d", to, ok, cyc, k + 10);
    else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++;
    if (wr_addr_q.size() != 2 || done !== 1'b1)
      $display("FAIL b2b_write_count: got %0d writes done=%b expected 2 1", wr_addr_q.size(), done);
    else n_pass++;
    n_checks++;
    if (wr_addr_q.size() < 2)
      $display("FAIL b2b_words: got %0d writes expected 2", wr_addr_q.size());
    else if (wr_addr_q[0] !== 6'd0 || wr_data_q[0] !== 32'h11223344 || wr_cyc_q[0] != k + 4 ||
             wr_addr_q[1] !== 6'd1 || wr_data_q[1] !== 32'h55667788 || wr_cyc_q[1] != k + 9)
      $display("FAIL b2b_words: got %0d:%h@%0d %0d:%h@%0d expected 0:11223344@%0d 1:55667788@%0d",
               wr_addr_q[0], wr_data_q[0], wr_cyc_q[0], wr_addr_q[1], wr_data_q[1], wr_cyc_q[1],
               k + 4, k + 9);
    else n_pass++;
    len = '0;
  endtask

  task automatic test_full_memory();
    int k;
    bit to;
    bit ok;
    logic [DWL-1:0] exp_w;
    clear_writes();
    stim_q.delete();
    for (int i = 0; i < 256; i++) stim_q.push_back(8'($urandom));
    do_start(7'd64, k);
    stream(1'b1, -1, 3000, to);
    wait_done(20, ok);
    n_checks++;
    if (to || !ok || wr_addr_q.size() != 64)
      $display("FAIL full_count: timeout=%b done=%b writes %0d expected 0 1 64", to, ok, wr_addr_q.size());
    else n_pass++;
    for (int i = 0; i < 64 && i < wr_addr_q.size(); i++) begin
      exp_w = {stim_q[4*i], stim_q[4*i+1], stim_q[4*i+2], stim_q[4*i+3]};
      n_checks++;
      if (wr_addr_q[i] !== AWL'(i) || wr_data_q[i] !== exp_w)
        $display("FAIL full_word[%0d]: got addr %0d data %h expected %0d %h",
                 i, wr_addr_q[i], wr_data_q[i], i, exp_w);
      else n_pass++;
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || wr_addr_q.size() != 64)
      $display("FAIL full_done_holds: done=%b hold=%b writes %0d expected 1 0 64", done, cpu_hold, wr_addr_q.size());
    else n_pass++;
  endtask

  task automatic test_len_clamp();
    int k;
    bit to;
    bit ok;
    clear_writes();
    stim_q.delete();
    for (int i = 0; i < 256; i++) stim_q.push_back(8'(i));
    do_start(7'd100, k);
    stream(1'b0, -1, 400, to);
    wait_done(10, ok);
    n_checks++;
    if (to || !ok || cyc != k + 320)
      $display("FAIL clamp_done_time: timeout=%b done=%b cyc %0d expected done at %0d", to, ok, cyc, k + 320);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_addr_q.size() != 64)
      $display("FAIL clamp_count: got %0d writes expected 64", wr_addr_q.size());
    else if (wr_addr_q[63] !== 6'd63 || wr_data_q[63] !== 32'hFCFDFEFF)
      $display("FAIL clamp_last: got addr %0d data %h expected 63 fcfdfeff", wr_addr_q[63], wr_data_q[63]);
    else n_pass++;
  endtask

  task automatic test_len0_restart();
    int k;
    bit to;
    bit ok;
    apply_reset(3);
    clear_writes();
    do_start(7'd0, k);
    n_checks++;
    if ({done, cpu_hold, busy, byte_ready} !== 4'b1000)
      $display("FAIL len0_done: got done/hold/busy/ready=%b expected 1000", {done, cpu_hold, busy, byte_ready});
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (wr_addr_q.size() != 0)
      $display("FAIL len0_no_write: got %0d writes expected 0", wr_addr_q.size());
    else n_pass++;
    stim_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
    do_start(7'd2, k);
    n_checks++;
    if (done !== 1'b0 || cpu_hold !== 1'b1 || byte_ready !== 1'b1)
      $display("FAIL restart_drop: got done=%b hold=%b ready=%b expected 0 1 1", done, cpu_hold, byte_ready);
    else n_pass++;
    stream(1'b0, -1, 30, to);
    wait_done(10, ok);
    n_checks++;
    if (to || !ok || cyc != k + 10)
      $display("FAIL restart_done_time: timeout=%b done=%b cyc %0d expected %0d", to, ok, cyc, k + 10);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (wr_addr_q.size() != 2)
      $display("FAIL restart_count: got %0d writes expected 2", wr_addr_q.size());
    else if (wr_addr_q[0] !== 6'd0 || wr_data_q[0] !== 32'hA0A1A2A3 ||
             wr_addr_q[1] !== 6'd1 || wr_data_q[1] !== 32'hA4A5A6A7)
      $display("FAIL restart_words: got %0d:%h %0d:%h expected 0:a0a1a2a3 1:a4a5a6a7",
               wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int k;
    bit to;
    bit ok;
    logic [OW-1:0] obs;
    logic [OW-1:0] exp_v;
    exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {AWL{1'b0}}, {DWL{1'b0}}};
    apply_reset(2);
    clear_writes();
    stim_q.delete();
    for (int i = 0; i < 14; i++) stim_q.push_back(8'(3 * i + 1));
    do_start(7'd4, k);
    stream(1'b0, -1, 40, to);
    n_checks++;
    if (to || wr_addr_q.size() != 3 || byte_ready !== 1'b1)
      $display("FAIL async_pre: timeout=%b writes %0d ready=%b expected 0 3 1", to, wr_addr_q.size(), byte_ready);
    else n_pass++;
    // Assert reset between clock edges; outputs must follow without an edge.
    #2 rst_n = 1'b0;
    #1;
    obs = {byte_ready, imwe, busy, done, cpu_hold, imwa, imwd};
    n_checks++;
    if (obs !== exp_v) $display("FAIL async_immediate: got %h expected %h", obs, exp_v);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (byte_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL async_idle_after: ready=%b busy=%b done=%b expected 0 0 0", byte_ready, busy, done);
    else n_pass++;
    clear_writes();
    stim_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    do_start(7'd1, k);
    stream(1'b0, -1, 20, to);
    wait_done(10, ok);
    @(negedge clk);
    n_checks++;
    if (to || !ok || wr_addr_q.size() != 1)
      $display("FAIL async_reload_count: timeout=%b done=%b writes %0d expected 0 1 1", to, ok, wr_addr_q.size());
    else if (wr_addr_q[0] !== 6'd0 || wr_data_q[0] !== 32'hA1B2C3D4)
      $display("FAIL async_reload_word: got addr %0d data %h expected 0 a1b2c3d4", wr_addr_q[0], wr_data_q[0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_full_memory();
    test_len_clamp();
    test_len0_restart();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_memory_loader.md
# instruction_memory_loader

Boot-time writer for the pipelined core's instruction memory. It accepts a byte stream over a valid/ready handshake and packs each group of 4 bytes into a 32-bit instruction, big-endian. It writes each word through a synchronous write port at consecutive word addresses starting at 0. The core is held off (CPU_HOLD) until the requested number of words has been written.

## Interface

Parameters:
- AWL, 6, instruction-memory word-address width.
- DWL, 32, instruction width in bits; must be a multiple of 8. Bytes per word BPW = DWL/8.
- DEPTH, 2**AWL, number of words in instruction memory.

Ports:
- CLK  input  1  clock, rising edge.
- RST_n  input  1  reset; asynchronous, active-low.
- START  input  1  single-cycle request to begin a load session; sampled only in IDLE or DONE.
- LEN  input  AWL+1  number of words to load, latched on accepted START; legal range 0..DEPTH.
- BYTE_IN  input  8  stream data byte.
- BYTE_VALID  input  1  BYTE_IN holds a valid byte.
- BYTE_READY  output  1  loader accepts a byte this cycle.
- IMWE  output  1  instruction-memory write enable, one cycle per word.
- IMWA  output  AWL  instruction-memory write address.
- IMWD  output  DWL  instruction-memory write data.
- BUSY  output  1  session in progress (COLLECT or WRITE).
- DONE  output  1  last session completed; CPU may run.
- CPU_HOLD  output  1  holds the pipeline; high in every state except DONE.

## Operation

- States: IDLE, COLLECT, WRITE, DONE. All outputs are registered or decoded from state only. BYTE_READY has no combinational path from BYTE_VALID.
- IDLE
  - START=1: latch LEN, clear word counter, address and byte counter.
  - If LEN==0, go to DONE; otherwise go to COLLECT.
- COLLECT
  - BYTE_READY=1.
  - Handshake occurs when BYTE_VALID & BYTE_READY at a rising edge. On each handshake: shift register <= {shift[DWL-9:0], BYTE_IN}, so the first byte ends up in bits [DWL-1:DWL-8]. Byte counter increments.
  - On the BPW-th handshake: go to WRITE with IMWD = the assembled word and IMWA = the current address.
  - BYTE_VALID low: wait indefinitely; no timeout.
- WRITE
  - IMWE=1 for exactly one cycle; BYTE_READY=0.
  - Next edge: word counter +1, address +1, byte counter cleared.
  - If the incremented word counter equals latched LEN, go to DONE; else go to COLLECT.
- DONE
  - DONE=1, CPU_HOLD=0, BUSY=0.
  - START=1 starts a new session exactly as from IDLE; DONE drops the next cycle.
- START in COLLECT/WRITE: ignored. LEN changes mid-session: no effect.
- LEN > DEPTH: not legal. The loader clamps the latched value to DEPTH.
- Address arithmetic: the word counter is AWL+1 bits, so LEN=DEPTH terminates correctly. IMWA is AWL bits and reaches DEPTH-1 on the final write; it never wraps within a legal session.
- IMWA/IMWD hold their last written values outside WRITE. Only IMWE qualifies a write.

## Timing

- Reset (RST_n=0, asynchronous):
  - State=IDLE.
  - BYTE_READY=0, IMWE=0, IMWA=0, IMWD=0, BUSY=0, DONE=0, CPU_HOLD=1.
  - Counters and shift register cleared.
- Reset asserted mid-session: everything returns to reset values immediately. Words already written are not retracted. A new START is required after reset deasserts.
- Latency:
  - START at edge k → COLLECT (BYTE_READY=1) from cycle k+1.
  - With BYTE_VALID held high, each word takes BPW+1 cycles: 4 accept cycles, then 1 WRITE cycle.
  - DONE rises the cycle after the final WRITE cycle.
  - LEN=N with continuous valid → DONE high at cycle k+1+5N.
  - LEN=0 → DONE high at cycle k+1.
- Byte-stream stalls (BYTE_VALID low) add cycles one-for-one; partial-word state is preserved.
- BYTE_READY is 0 during WRITE. A source holding BYTE_VALID high sees no acceptance that cycle, and the byte is taken in the next COLLECT cycle.

## Test plan

- Reset values: RST_n low for 3 cycles → CPU_HOLD=1, all other outputs 0. Release, no START → outputs unchanged for 20 cycles.
- Single word: LEN=1, bytes 8C,01,00,04 streamed back-to-back → exactly one IMWE pulse with IMWA=0, IMWD=32'h8C010004, in cycle k+5. DONE=1 and CPU_HOLD=0 at k+6.
- Full memory: LEN=64, random bytes with random BYTE_VALID gaps → 64 IMWE pulses at IMWA 0..63 in order. Data matches the scoreboard and no write occurs after address 63. DONE then holds.
- Edge handshakes: BYTE_VALID high throughout a WRITE cycle → that byte is not accepted during WRITE and is captured as byte 0 of the next word. START pulsed mid-session → ignored, LEN unchanged.
- LEN=0 and restart: START with LEN=0 → DONE next cycle, no IMWE. Then START with LEN=2 from DONE → DONE drops, 2 words written at addresses 0 and 1, DONE re-asserts.
- Async reset mid-word: assert RST_n low after 2 bytes of word 3 → immediate IDLE and reset output values. Afterwards START with LEN=1 → writes address 0 with the freshly sent 4 bytes; no stale byte leaks into the word.
